// File: rtl/mc_control_pkg.sv
// Shared constants for the TSC multi-cycle controller: ISA opcodes/funcs, ALU ops,
// controller state encoding and the bundled strobe record.
package mc_control_pkg;

    localparam int unsigned opcode_length    = 4;
    localparam int unsigned func_code_length = 6;

    localparam logic [opcode_length-1:0] OPCODE_ADI   = 4'd4;
    localparam logic [opcode_length-1:0] OPCODE_LHI   = 4'd6;
    localparam logic [opcode_length-1:0] OPCODE_LWD   = 4'd7;
    localparam logic [opcode_length-1:0] OPCODE_SWD   = 4'd8;
    localparam logic [opcode_length-1:0] OPCODE_JMP   = 4'd9;
    localparam logic [opcode_length-1:0] OPCODE_RTYPE = 4'd15;

    localparam logic [func_code_length-1:0] FUNC_ADD = 6'd0;
    localparam logic [func_code_length-1:0] FUNC_WWD = 6'd28;
    localparam logic [func_code_length-1:0] FUNC_HLT = 6'd29;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ID  = 4'b1000;
    localparam logic [3:0] OP_LHI = 4'b1001;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic       readM;
        logic       writeM;
        logic       IorD;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCSrc;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrc;
        logic       MemtoReg;
        logic [3:0] ALUOperation;
        logic       isWWD;
    } strobes_t;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational decode of (state, latched opcode/func, memory completion) into
// datapath strobes, next state and the retire pulse.
module mc_control_decode
    import mc_control_pkg::*;
(
    input  state_t                      state,
    input  logic [opcode_length-1:0]    opcode,
    input  logic [func_code_length-1:0] func_code,
    input  logic                        inputReady,
    output strobes_t                    strobes,
    output state_t                      next_state,
    output logic                        retire
);

    logic is_rtype, is_add, is_lwd, is_swd, is_lhi;

    assign is_rtype = (opcode == OPCODE_RTYPE);
    assign is_add   = is_rtype && (func_code == FUNC_ADD);
    assign is_lwd   = (opcode == OPCODE_LWD);
    assign is_swd   = (opcode == OPCODE_SWD);
    assign is_lhi   = (opcode == OPCODE_LHI);

    always_comb begin
        strobes    = '0;
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_IF: begin
                strobes.readM = 1'b1;
                if (inputReady) begin
                    strobes.IRWrite = 1'b1;
                    strobes.PCWrite = 1'b1;
                    next_state      = S_ID;
                end
            end
            S_ID: begin
                if (opcode == OPCODE_JMP) begin
                    strobes.PCWrite = 1'b1;
                    strobes.PCSrc   = 1'b1;
                    retire          = 1'b1;
                    next_state      = S_IF;
                end else if (is_rtype) begin
                    case (func_code)
                        FUNC_WWD: begin
                            strobes.isWWD        = 1'b1;
                            strobes.ALUOperation = OP_ID;
                            retire               = 1'b1;
                            next_state           = S_IF;
                        end
                        FUNC_HLT: next_state = S_HALT;
                        FUNC_ADD: next_state = S_EX;
                        default: begin
                            retire     = 1'b1;
                            next_state = S_IF;
                        end
                    endcase
                end else if (opcode == OPCODE_ADI || is_lhi || is_lwd || is_swd) begin
                    next_state = S_EX;
                end else begin
                    retire     = 1'b1;
                    next_state = S_IF;
                end
            end
            S_EX: begin
                strobes.ALUOperation = is_lhi ? OP_LHI : OP_ADD;
                strobes.ALUSrc       = !is_add;
                next_state           = (is_lwd || is_swd) ? S_MEM : S_WB;
            end
            S_MEM: begin
                strobes.IorD   = 1'b1;
                strobes.readM  = is_lwd;
                strobes.writeM = is_swd;
                if (inputReady) begin
                    if (is_lwd) begin
                        next_state = S_WB;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_IF;
                    end
                end
            end
            S_WB: begin
                strobes.RegWrite = 1'b1;
                strobes.RegDst   = is_add;
                strobes.MemtoReg = is_lwd;
                retire           = 1'b1;
                next_state       = S_IF;
            end
            S_HALT: next_state = S_HALT;
            default: next_state = S_IF;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// TSC multi-cycle sequencing controller: state register, sticky halt flag and
// retired-instruction counter around the combinational decode.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [opcode_length-1:0]    opcode,
    input  logic [func_code_length-1:0] func_code,
    input  logic                        inputReady,
    output logic                        readM,
    output logic                        writeM,
    output logic                        IorD,
    output logic                        IRWrite,
    output logic                        PCWrite,
    output logic                        PCSrc,
    output logic                        RegWrite,
    output logic                        RegDst,
    output logic                        ALUSrc,
    output logic                        MemtoReg,
    output logic [3:0]                  ALUOperation,
    output logic                        isWWD,
    output logic                        halted,
    output logic [CNT_W-1:0]            num_inst
);

    state_t   state, next_state;
    strobes_t strobes;
    logic     retire;

    // Masking completion with reset keeps IRWrite/PCWrite low while reset holds S_IF.
    mc_control_decode u_decode (
        .state      (state),
        .opcode     (opcode),
        .func_code  (func_code),
        .inputReady (inputReady & reset_n),
        .strobes    (strobes),
        .next_state (next_state),
        .retire     (retire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IF;
            halted   <= 1'b0;
            num_inst <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_HALT) halted <= 1'b1;
            if (retire) num_inst <= num_inst + CNT_W'(1);
        end
    end

    assign readM        = strobes.readM;
    assign writeM       = strobes.writeM;
    assign IorD         = strobes.IorD;
    assign IRWrite      = strobes.IRWrite;
    assign PCWrite      = strobes.PCWrite;
    assign PCSrc        = strobes.PCSrc;
    assign RegWrite     = strobes.RegWrite;
    assign RegDst       = strobes.RegDst;
    assign ALUSrc       = strobes.ALUSrc;
    assign MemtoReg     = strobes.MemtoReg;
    assign ALUOperation = strobes.ALUOperation;
    assign isWWD        = strobes.isWWD;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected outputs are queued by the
// stimulus and compared by a negedge monitor.
module tb_mc_control;
    import mc_control_pkg::*;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          inputReady = 1'b0;
    logic [3:0]    opcode = '0;
    logic [5:0]    func_code = '0;
    logic          readM, writeM, IorD, IRWrite, PCWrite, PCSrc;
    logic          RegWrite, RegDst, ALUSrc, MemtoReg, isWWD, halted;
    logic [3:0]    ALUOperation;
    logic [CW-1:0] num_inst;

    mc_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
        .inputReady(inputReady), .readM(readM), .writeM(writeM), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .ALUOperation(ALUOperation), .isWWD(isWWD), .halted(halted), .num_inst(num_inst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          readM, writeM, IorD, IRWrite, PCWrite, PCSrc;
        logic          RegWrite, RegDst, ALUSrc, MemtoReg;
        logic [3:0]    alu;
        logic          isWWD, halted;
        logic [CW-1:0] num;
    } obs_t;

    typedef enum {K_ADD, K_ADI, K_LHI, K_LWD, K_SWD, K_JMP, K_WWD, K_HLT, K_NOP, K_BADF} kind_t;

    obs_t          exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] cnt = '0;

    always @(negedge clk) begin
        obs_t  e, a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {readM, writeM, IorD, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
                 ALUSrc, MemtoReg, ALUOperation, isWWD, halted, num_inst};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s @%0t: got %h expected %h", n, $time, a, e);
            end
        end
    end

    task automatic step(input obs_t e, input logic rdy, input string n);
        e.num = cnt;
        exp_q.push_back(e);
        name_q.push_back(n);
        inputReady = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        obs_t e;
        reset_n = 1'b0;
        cnt = '0;
        e = '0;
        e.readM = 1'b1;
        step(e, 1'b1, "reset");
        reset_n = 1'b1;
    endtask

    task automatic if_phase(input int unsigned if_wait);
        obs_t e;
        for (int unsigned w = 0; w < if_wait; w++) begin
            e = '0; e.readM = 1'b1;
            step(e, 1'b0, "if_wait");
        end
        e = '0; e.readM = 1'b1; e.IRWrite = 1'b1; e.PCWrite = 1'b1;
        step(e, 1'b1, "if");
    endtask

    task automatic run(input kind_t k, input int unsigned if_wait, input int unsigned mem_wait);
        obs_t e;
        case (k)
            K_ADD:  begin opcode = OPCODE_RTYPE; func_code = FUNC_ADD; end
            K_ADI:  opcode = OPCODE_ADI;
            K_LHI:  opcode = OPCODE_LHI;
            K_LWD:  opcode = OPCODE_LWD;
            K_SWD:  opcode = OPCODE_SWD;
            K_JMP:  opcode = OPCODE_JMP;
            K_WWD:  begin opcode = OPCODE_RTYPE; func_code = FUNC_WWD; end
            K_HLT:  begin opcode = OPCODE_RTYPE; func_code = FUNC_HLT; end
            K_NOP:  opcode = 4'd0;
            K_BADF: begin opcode = OPCODE_RTYPE; func_code = 6'd5; end
            default: opcode = 4'd0;
        endcase
        if_phase(if_wait);
        e = '0;
        case (k)
            K_JMP: begin
                e.PCWrite = 1'b1; e.PCSrc = 1'b1;
                step(e, 1'b1, "id_jmp");
                cnt = cnt + 1'b1;
                return;
            end
            K_WWD: begin
                e.isWWD = 1'b1; e.alu = OP_ID;
                step(e, 1'b1, "id_wwd");
                cnt = cnt + 1'b1;
                return;
            end
            K_NOP, K_BADF: begin
                step(e, 1'b1, "id_other");
                cnt = cnt + 1'b1;
                return;
            end
            K_HLT: begin
                step(e, 1'b1, "id_hlt");
                for (int unsigned i = 0; i < 20; i++) begin
                    e = '0; e.halted = 1'b1;
                    step(e, 1'b1, "halt");
                end
                return;
            end
            default: step(e, 1'b1, "id");
        endcase
        e = '0;
        e.alu = (k == K_LHI) ? OP_LHI : OP_ADD;
        e.ALUSrc = (k != K_ADD);
        step(e, 1'b1, "ex");
        if (k == K_LWD || k == K_SWD) begin
            e = '0; e.IorD = 1'b1; e.readM = (k == K_LWD); e.writeM = (k == K_SWD);
            for (int unsigned w = 0; w < mem_wait; w++) step(e, 1'b0, "mem_wait");
            step(e, 1'b1, "mem");
            if (k == K_SWD) begin
                cnt = cnt + 1'b1;
                return;
            end
        end
        e = '0;
        e.RegWrite = 1'b1; e.RegDst = (k == K_ADD); e.MemtoReg = (k == K_LWD);
        step(e, 1'b1, "wb");
        cnt = cnt + 1'b1;
    endtask

    initial begin
        obs_t e;
        @(posedge clk);
        #1;
        reset_cycle();
        run(K_ADI, 0, 0);
        run(K_JMP, 0, 0);
        run(K_LWD, 0, 3);
        run(K_SWD, 0, 0);
        run(K_ADD, 0, 0);
        run(K_LHI, 0, 0);
        run(K_NOP, 0, 0);
        run(K_BADF, 0, 0);
        run(K_JMP, 2, 0);
        run(K_SWD, 1, 2);

        // Abandon a store mid-wait with a reset pulse.
        opcode = OPCODE_SWD;
        if_phase(0);
        e = '0; step(e, 1'b1, "id_swd_abort");
        e = '0; e.alu = OP_ADD; e.ALUSrc = 1'b1; step(e, 1'b1, "ex_swd_abort");
        e = '0; e.IorD = 1'b1; e.writeM = 1'b1; step(e, 1'b0, "mem_wait_abort");
        reset_cycle();
        run(K_JMP, 0, 0);

        // Counter wrap: 2**CW retirements from here lands back on the current value.
        for (int unsigned i = 0; i < (1 << CW); i++) run(K_JMP, 0, 0);
        reset_cycle();
        run(K_WWD, 0, 0);
        run(K_HLT, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
